// File: rtl/crank_cam_gen.sv
// rtl/crank_cam_gen.sv - trigger-wheel crank/cam signal generator with missing-tooth gap
module crank_cam_gen #(
    parameter int TEETH     = 60,
    parameter int MISSING   = 2,
    parameter int TICK_W    = 6,
    parameter int PRESC_W   = 16,
    parameter int PRESC_RST = 0,
    parameter int CAM_ON    = 4,
    parameter int CAM_OFF   = 54
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic [PRESC_W-1:0] presc_top,
    input  logic               presc_load,
    input  logic               cam_ena,
    output logic               cap,
    output logic               cam,
    output logic [7:0]         tooth,
    output logic [TICK_W+1:0]  tick,
    output logic               rev_strobe,
    output logic               phase,
    output logic               pending
);

    localparam int TW = TICK_W + 2;
    localparam logic [7:0]         LAST       = 8'(TEETH - MISSING - 1);
    localparam logic [TW-1:0]      NORM_TOP   = TW'(2**TICK_W - 1);
    localparam logic [TW-1:0]      GAP_TOP    = TW'((MISSING + 1) * 2**TICK_W - 1);
    localparam logic [TW-1:0]      NORM_HALF  = TW'(2**(TICK_W - 1));
    localparam logic [TW-1:0]      GAP_HALF   = TW'((MISSING + 1) * 2**(TICK_W - 1));
    localparam logic [TW-1:0]      TICK_ONE   = TW'(1);
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
    localparam logic [PRESC_W-1:0] PRESC_INIT = PRESC_W'(PRESC_RST);
    localparam logic [7:0]         CAM_ON_T   = 8'(CAM_ON);
    localparam logic [7:0]         CAM_OFF_T  = 8'(CAM_OFF);
    localparam logic [7:0]         TOOTH_ONE  = 8'd1;

    logic [PRESC_W-1:0] presc_cnt;
    logic [PRESC_W-1:0] presc_act;
    logic [PRESC_W-1:0] shadow;

    logic          tick_en;
    logic          tooth_end;
    logic          wrap;
    logic [TW-1:0] tooth_top;
    logic [TW-1:0] tick_n;
    logic [TW-1:0] cap_half;
    logic [7:0]    tooth_n;
    logic          phase_n;

    // >= rather than == so a top lowered while halted cannot strand the counter above it
    always_comb begin
        tooth_top = (tooth == LAST) ? GAP_TOP : NORM_TOP;
        tick_en   = ena && (presc_cnt >= presc_act);
        tooth_end = tick_en && (tick == tooth_top);
        wrap      = tooth_end && (tooth == LAST);
        tick_n    = tick;
        tooth_n   = tooth;
        phase_n   = phase;
        if (tick_en) begin
            if (tooth_end) begin
                tick_n = '0;
                if (wrap) begin
                    tooth_n = '0;
                    phase_n = ~phase;
                end else begin
                    tooth_n = tooth + TOOTH_ONE;
                end
            end else begin
                tick_n = tick + TICK_ONE;
            end
        end
        cap_half = (tooth_n == LAST) ? GAP_HALF : NORM_HALF;
    end

    // cap and cam are derived from the next tick/tooth so they stay aligned with them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_cnt  <= '0;
            presc_act  <= PRESC_INIT;
            shadow     <= PRESC_INIT;
            pending    <= 1'b0;
            tick       <= '0;
            tooth      <= '0;
            phase      <= 1'b0;
            rev_strobe <= 1'b0;
            cap        <= 1'b0;
            cam        <= 1'b0;
        end else begin
            if (ena) begin
                presc_cnt <= tick_en ? '0 : presc_cnt + PRESC_ONE;
            end
            tick       <= tick_n;
            tooth      <= tooth_n;
            phase      <= phase_n;
            rev_strobe <= wrap;
            cap        <= (tick_n >= cap_half);
            cam        <= cam_ena & phase_n & (tooth_n >= CAM_ON_T) & (tooth_n < CAM_OFF_T);
            if (presc_load) begin
                shadow <= presc_top;
                if (!ena || wrap) begin
                    presc_act <= presc_top;
                    pending   <= 1'b0;
                end else begin
                    pending <= 1'b1;
                end
            end else if (wrap && pending) begin
                presc_act <= shadow;
                pending   <= 1'b0;
            end
        end
    end

endmodule
